// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Holds word width, FSM encodings, master indices and the latched request.
package dmem_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic              who;
    logic              we;
    logic [3:0]        be;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wd;
  } txn_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot grant and the pointer to use next.
// A lone requester always wins; on a tie the pointer decides.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  logic pick0;
  logic pick1;

  assign pick0 = req[0] && (!req[1] || ptr == M0);
  assign pick1 = req[1] && (!req[0] || ptr == M1);

  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    unique case (1'b1)
      pick0: begin
        gnt     = 2'b01;
        ptr_nxt = M1;
      end
      pick1: begin
        gnt     = 2'b10;
        ptr_nxt = M0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two masters onto one word-addressed data memory.
// Grant in IDLE, one ACCESS cycle, then a registered done pulse.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [WORD_W-1:0] m0_addr,
  input  logic [WORD_W-1:0] m0_wd,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic              m0_err,
  output logic [WORD_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [WORD_W-1:0] m1_addr,
  input  logic [WORD_W-1:0] m1_wd,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic              m1_err,
  output logic [WORD_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wd,
  input  logic [WORD_W-1:0] mem_rd
);

  localparam logic [WORD_W-1:0] AMASK =
    (WORD_W'(1) << WIDTH) - WORD_W'(1);

  state_t            state;
  logic              ptr;
  txn_t              lat;
  txn_t              nxt;
  logic [1:0]        pick;
  logic              ptr_nxt;
  logic              idle_ok;
  logic              acc;
  logic              in_range;
  logic [WORD_W-1:0] rdata_nxt;

  rr_pick2 u_pick (
    .req     ({m1_req, m0_req}),
    .ptr     (ptr),
    .gnt     (pick),
    .ptr_nxt (ptr_nxt)
  );

  assign idle_ok = (state == IDLE) && !reset;
  assign m0_gnt  = idle_ok && pick[0];
  assign m1_gnt  = idle_ok && pick[1];

  // Reset in ACCESS must not reach memory, so it masks the drive too.
  assign acc      = (state == ACCESS) && !reset;
  assign in_range = (lat.addr >> WIDTH) == '0;

  assign mem_we   = acc && lat.we && in_range;
  assign mem_be   = acc ? lat.be : 4'd0;
  assign mem_addr = acc ? ((lat.addr & AMASK) >> 2) : '0;
  assign mem_wd   = acc ? lat.wd : '0;

  assign rdata_nxt = (in_range && !lat.we) ? mem_rd : '0;

  always_comb begin
    nxt = '0;
    if (pick[1])
      nxt = '{who: M1, we: m1_we, be: m1_be,
              addr: m1_addr, wd: m1_wd};
    else
      nxt = '{who: M0, we: m0_we, be: m0_be,
              addr: m0_addr, wd: m0_wd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= M0;
      lat      <= '0;
      m0_done  <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_done  <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      m0_done  <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_done  <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (|pick) begin
            state <= ACCESS;
            ptr   <= ptr_nxt;
            lat   <= nxt;
          end
        end
        ACCESS: begin
          state <= IDLE;
          if (lat.who == M1) begin
            m1_done  <= 1'b1;
            m1_err   <= !in_range;
            m1_rdata <= rdata_nxt;
          end else begin
            m0_done  <= 1'b1;
            m0_err   <= !in_range;
            m0_rdata <= rdata_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle,
// plus literal pins for the directed scenarios.
module tb_dmem_arbiter;

  localparam int W  = 12;
  localparam int NW = 1 << (W - 2);

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } tx_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_gnt(m0_gnt),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_gnt(m1_gnt),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Shared memory driven by the DUT
  logic [31:0] mem [NW] = '{default: 32'd0};
  assign mem_rd = mem[mem_addr[W-3:0]];
  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b])
          mem[mem_addr[W-3:0]][8*b +: 8] <= mem_wd[8*b +: 8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: in-flight access, pending done, priority, reference memory
  logic [31:0] ref_mem [NW] = '{default: 32'd0};
  bit          a_v, a_who, d_v, d_who, d_err, prio;
  tx_t         a_t;
  logic [31:0] d_rd;

  tx_t q0[$], q1[$];
  bit  saw_g0, saw_g1, rst_cmd;

  int          gnt_cyc[2], done_cyc[2], done_cnt[2];
  logic [31:0] done_rd[2];
  bit          done_err[2];
  int          wr_cnt, wr_cyc;
  logic [31:0] wr_addr;
  int          gseq[$], gcyc[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  function automatic tx_t mk(bit we, logic [3:0] be,
                             logic [31:0] addr, logic [31:0] wd);
    tx_t t;
    t.we = we; t.be = be; t.addr = addr; t.wd = wd;
    return t;
  endfunction

  task automatic drive();
    if (saw_g0 && q0.size() > 0) void'(q0.pop_front());
    if (saw_g1 && q1.size() > 0) void'(q1.pop_front());
    reset  = rst_cmd;
    m0_req = q0.size() > 0;
    m1_req = q1.size() > 0;
    {m0_we, m0_be, m0_addr, m0_wd} = '0;
    {m1_we, m1_be, m1_addr, m1_wd} = '0;
    if (q0.size() > 0) begin
      m0_we = q0[0].we; m0_be = q0[0].be;
      m0_addr = q0[0].addr; m0_wd = q0[0].wd;
    end
    if (q1.size() > 0) begin
      m1_we = q1[0].we; m1_be = q1[0].be;
      m1_addr = q1[0].addr; m1_wd = q1[0].wd;
    end
  endtask

  task automatic compare_and_model();
    bit e0 = 0, e1 = 0, inr, acc;
    int idx;
    if (!reset && !a_v) begin
      if (m0_req && m1_req) begin
        e0 = !prio; e1 = prio;
      end else begin
        e0 = m0_req; e1 = m1_req;
      end
    end
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("gnt_onehot", m0_gnt & m1_gnt, 0);
    inr = (a_t.addr >> W) == 0;
    acc = a_v && !reset;
    idx = int'((a_t.addr >> 2) % NW);
    chk("mem_we", mem_we, acc && a_t.we && inr);
    if (!reset) begin
      chk("mem_be", mem_be, acc ? a_t.be : 4'd0);
      chk("mem_addr", mem_addr, acc ? idx : 0);
      chk("mem_wd", mem_wd, acc ? a_t.wd : 0);
    end
    chk("m0_done", m0_done, d_v && !d_who);
    chk("m1_done", m1_done, d_v && d_who);
    if (d_v && !d_who) begin
      chk("m0_err", m0_err, d_err);
      chk("m0_rdata", m0_rdata, d_rd);
    end
    if (d_v && d_who) begin
      chk("m1_err", m1_err, d_err);
      chk("m1_rdata", m1_rdata, d_rd);
    end
    // Event logs from the DUT for the literal pins
    saw_g0 = m0_gnt; saw_g1 = m1_gnt;
    if (m0_gnt) begin gnt_cyc[0] = cyc; gseq.push_back(0); gcyc.push_back(cyc); end
    if (m1_gnt) begin gnt_cyc[1] = cyc; gseq.push_back(1); gcyc.push_back(cyc); end
    if (mem_we) begin wr_cnt++; wr_cyc = cyc; wr_addr = mem_addr; end
    if (m0_done) begin
      done_cyc[0] = cyc; done_rd[0] = m0_rdata;
      done_err[0] = m0_err; done_cnt[0]++;
    end
    if (m1_done) begin
      done_cyc[1] = cyc; done_rd[1] = m1_rdata;
      done_err[1] = m1_err; done_cnt[1]++;
    end
    // Advance the model across the coming edge
    if (reset) begin
      a_v = 0; d_v = 0; prio = 0;
    end else begin
      d_v = a_v;
      if (a_v) begin
        d_who = a_who;
        d_err = !inr;
        d_rd  = (inr && !a_t.we) ? ref_mem[idx] : 32'd0;
        if (inr && a_t.we)
          for (int b = 0; b < 4; b++)
            if (a_t.be[b]) ref_mem[idx][8*b +: 8] = a_t.wd[8*b +: 8];
      end
      a_v = e0 || e1;
      if (e0) begin
        a_who = 0; prio = 1;
        a_t = mk(m0_we, m0_be, m0_addr, m0_wd);
      end else if (e1) begin
        a_who = 1; prio = 0;
        a_t = mk(m1_we, m1_be, m1_addr, m1_wd);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    compare_and_model();
  endtask

  task automatic run_idle(string name, int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || a_v || d_v) && n < budget) begin
      step();
      n++;
    end
    step();
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout: got %0d cycles required < %0d", name, n, budget);
    end
  endtask

  initial begin
    int wc, dc;
    rst_cmd = 1;
    reset = 1;
    {m0_req, m0_we, m0_be, m0_addr, m0_wd} = '0;
    {m1_req, m1_we, m1_be, m1_addr, m1_wd} = '0;
    repeat (3) step();
    chk("reset_m0_done", m0_done, 0);
    chk("reset_mem_addr", mem_addr, 0);
    rst_cmd = 0;
    step();

    // Single full-word store
    q0.push_back(mk(1, 4'hF, 32'h10, 32'hAABBCCDD));
    run_idle("s1", 20);
    chk("s1_wr_addr", wr_addr, 4);
    chk("s1_wr_cyc", wr_cyc - gnt_cyc[0], 1);
    chk("s1_done_lat", done_cyc[0] - gnt_cyc[0], 2);
    chk("s1_err", done_err[0], 0);

    // Byte store then load
    q1.push_back(mk(1, 4'b0001, 32'h10, 32'h000000EE));
    q1.push_back(mk(0, 4'h0, 32'h10, 32'h0));
    run_idle("s2", 20);
    chk("s2_rdata", done_rd[1], 32'hAABBCCEE);

    // be=0 store leaves the word alone; low address bits ignored
    q0.push_back(mk(1, 4'b0000, 32'h13, 32'hFFFFFFFF));
    q0.push_back(mk(0, 4'h0, 32'h11, 32'h0));
    run_idle("be0", 20);
    chk("be0_rdata", done_rd[0], 32'hAABBCCEE);

    // Contention straight out of reset
    rst_cmd = 1;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(0, 4'h0, 32'h10, 32'h0));
      q1.push_back(mk(0, 4'h0, 32'h10, 32'h0));
    end
    step(); step();
    rst_cmd = 0;
    gseq.delete(); gcyc.delete();
    run_idle("s3", 40);
    chk("s3_count", gseq.size(), 6);
    if (gseq.size() >= 4) begin
      chk("s3_g0", gseq[0], 0);
      chk("s3_g1", gseq[1], 1);
      chk("s3_g2", gseq[2], 0);
      chk("s3_g3", gseq[3], 1);
      chk("s3_gap", gcyc[1] - gcyc[0], 2);
      chk("s3_gap2", gcyc[3] - gcyc[2], 2);
    end

    // Out-of-range store, then load of word 0
    wc = wr_cnt;
    q0.push_back(mk(1, 4'hF, 32'h1000, 32'h12345678));
    run_idle("s4", 20);
    chk("s4_no_write", wr_cnt, wc);
    chk("s4_err", done_err[0], 1);
    chk("s4_rdata", done_rd[0], 0);
    q0.push_back(mk(0, 4'h0, 32'h0, 32'h0));
    run_idle("s4b", 20);
    chk("s4b_rdata", done_rd[0], 0);
    chk("s4b_err", done_err[0], 0);

    // Reset in the ACCESS cycle of an m1 store
    wc = wr_cnt;
    dc = done_cnt[1];
    q1.push_back(mk(1, 4'hF, 32'h20, 32'h00000055));
    begin
      int n = 0;
      saw_g1 = 0;
      while (!saw_g1 && n < 10) begin step(); n++; end
      checks++;
      if (!saw_g1) begin
        errors++;
        $display("FAIL s5_grant timeout: got none required m1_gnt");
      end
    end
    rst_cmd = 1;
    step();
    rst_cmd = 0;
    step(); step();
    chk("s5_no_write", wr_cnt, wc);
    chk("s5_mem8", mem[8], 0);
    chk("s5_no_done", done_cnt[1], dc);
    gseq.delete();
    q0.push_back(mk(0, 4'h0, 32'h0, 32'h0));
    q1.push_back(mk(0, 4'h0, 32'h0, 32'h0));
    run_idle("s5b", 20);
    chk("s5_first", gseq.size() > 0 ? gseq[0] : -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
